text_console_writer: RTL and testbench
======================================

Name: text_console_writer

Overview:
- Wishbone-style bus initiator that drives the text-mode video character RAM slave.
- Takes a byte stream of characters and writes it to the 80x60 text grid at a hardware cursor (linear address = row*80+col).
- Handles CR, LF, TAB, BS and FF; scrolls by bus read/write copy when output runs past the last row.
- Sits between a CPU/UART character source and the video block's bus port.

Parameters:
- COLS, 80, characters per row.
- ROWS, 60, rows on screen.
- ADDR_W, 13, bus address width; must hold COLS*ROWS-1.
- FILL, 8'h20, byte written when clearing screen or the scrolled-in row.

Ports:
- clk_25mhz  in  1  system/pixel clock, all logic on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- char_i  in  8  character byte.
- char_valid_i  in  1  char_i valid.
- char_ready_o  out  1  block can accept a character this cycle.
- busy_o  out  1  command in progress (inverse of char_ready_o).
- cur_col_o  out  7  cursor column.
- cur_row_o  out  6  cursor row.
- adr_o  out  ADDR_W  bus address.
- dat_o  out  32  write data; byte in [7:0], [31:8] zero.
- sel_o  out  4  byte select; always 4'b0001 while stb_o high, else 0.
- we_o  out  1  write enable.
- stb_o  out  1  strobe / cycle request.
- ack_i  in  1  slave acknowledge, may stay high multiple cycles.
- dat_i  in  32  read data; only [7:0] used, sampled when ack_i high on a read.

Behaviour:
- Reset (async, rst_ni=0): stb_o=we_o=0, sel_o=0, adr_o=0, dat_o=0, cursor=(0,0), char_ready_o=1, busy_o=0. Reset mid-transaction drops stb_o immediately and abandons the command.
- Input handshake: transfer when char_valid_i & char_ready_o. char_ready_o=1 only in IDLE and falls the cycle after acceptance.
- Bus sub-FSM:
  - States: B_IDLE, B_REQ, B_DROP.
  - A transaction starts only when ack_i=0, so a lingering ack after reset or the previous cycle is tolerated.
  - B_REQ holds stb_o, adr_o, we_o, dat_o and sel_o stable until ack_i=1 is sampled; read data is captured on that edge.
  - B_DROP deasserts stb_o next cycle and waits for ack_i=0, then reports done.
- Main FSM states: IDLE, DECODE, PUT, SCR_RD, SCR_WR, FILL_WR, ADVANCE.
- Byte decode:
  - 0x0D CR: col=0.
  - 0x0A LF: col=0, row+1.
  - 0x09 TAB: col = next multiple of 8; reaching COLS wraps as LF.
  - 0x08 BS: col-1 if col>0, else unchanged; no bus write.
  - 0x0C FF: write FILL to all COLS*ROWS addresses 0..4799 ascending, then cursor=(0,0).
  - Any other byte: PUT writes it at row*COLS+col, then col+1. col=COLS-1 wraps to col 0, row+1.
- Row advance from ROWS-1 triggers a scroll:
  - For a = COLS .. COLS*ROWS-1: read a, write the byte to a-COLS.
  - Then write FILL to (ROWS-1)*COLS .. COLS*ROWS-1.
  - Cursor row stays ROWS-1.
- Scroll is completed before char_ready_o returns to 1.
- Address arithmetic: row*COLS computed as {row,6'b0}+{row,4'b0} for COLS=80, zero-extended to ADDR_W; no address ever exceeds COLS*ROWS-1.
- Latency with a 1-cycle-ack slave: byte accepted at cycle N, DECODE at N+1, stb_o high at N+2. A control-only byte (CR/LF-without-scroll/TAB/BS) returns char_ready_o=1 at N+2.
- char_valid_i while busy is ignored (not lost: source must hold it).

Decomposition:
- Shared package video_pkg: COLS, ROWS, ADDR_W, FILL, control-code constants (CC_BS=8'h08, CC_TAB=8'h09, CC_LF=8'h0A, CC_FF=8'h0C, CC_CR=8'h0D), and the main-state enum.
- Sub-module wb_single_master: the bus sub-FSM, with req/we/addr/wdata in and done/rdata out. It is reusable by other initiators.

Test Plan:
- Reset, then send 'A' (0x41) against a slave model acking 1 cycle after stb for 2 cycles -> one write with adr_o=0, dat_o=0x41, sel_o=0001, we_o=1; cursor (1,0); stb_o low until ack_i low before the next transaction.
- Cursor (79,10), send 0x42 -> write at adr 879, cursor (0,11); then BS -> cursor (0,11) with no bus activity.
- Cursor (5,3), send TAB, CR, LF -> cursor (8,3), then (0,3), then (0,4); no bus cycles.
- Preload row 1 with 0x31 and row 59 with 0x39, cursor (0,59), send LF:
  - 4720 reads and 4720 writes, then 80 FILL writes.
  - Row 0 holds 0x31, row 58 holds 0x39, row 59 holds 0x20.
  - Cursor (0,59).
- Send FF -> 4800 writes of 0x20 to addresses 0..4799 in order, cursor (0,0), char_ready_o=1 afterwards.
- Assert rst_ni=0 mid-scroll with ack_i high -> stb_o=0 asynchronously. After release the next 'Z' waits for ack_i=0, then writes at adr 0.

Source files
------------

// File: rtl/video_pkg.sv
// Shared constants, control codes and state encoding
// for the text-mode console writer and its bus initiator.
package video_pkg;

  localparam int COLS   = 80;
  localparam int ROWS   = 60;
  localparam int ADDR_W = 13;

  localparam logic [7:0] FILL = 8'h20;

  localparam logic [7:0] CC_BS  = 8'h08;
  localparam logic [7:0] CC_TAB = 8'h09;
  localparam logic [7:0] CC_LF  = 8'h0A;
  localparam logic [7:0] CC_FF  = 8'h0C;
  localparam logic [7:0] CC_CR  = 8'h0D;

  localparam logic [ADDR_W-1:0] COLS_A =
    ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] LAST_ADDR =
    ADDR_W'(COLS * ROWS - 1);
  localparam logic [ADDR_W-1:0] LAST_ROW_ADDR =
    ADDR_W'((ROWS - 1) * COLS);

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    PUT,
    SCR_RD,
    SCR_WR,
    FILL_WR,
    ADVANCE
  } main_state_t;

  // row*80 without a multiplier
  function automatic logic [ADDR_W-1:0] row_base(
    input logic [5:0] row
  );
    return ADDR_W'({row, 6'b0}) + ADDR_W'({row, 4'b0});
  endfunction

endpackage

// File: rtl/wb_single_master.sv
// Single-transfer Wishbone-style initiator: one read or
// write per request, tolerant of a slave ack that lingers.
module wb_single_master #(
  parameter int AW = 13
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic          done,
  output logic [31:0]   rdata,
  output logic [AW-1:0] adr_o,
  output logic [31:0]   dat_o,
  output logic [3:0]    sel_o,
  output logic          we_o,
  output logic          stb_o,
  input  logic          ack_i,
  input  logic [31:0]   dat_i
);

  typedef enum logic [1:0] {
    B_IDLE,
    B_REQ,
    B_DROP
  } bus_state_t;

  bus_state_t    state_q, state_d;
  logic [AW-1:0] adr_q;
  logic [31:0]   dat_q;
  logic [31:0]   rdata_q;
  logic          we_q;
  logic          launch;

  // never start while the previous ack is still high
  assign launch = (state_q == B_IDLE) && req && !ack_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= B_IDLE;
      adr_q   <= '0;
      dat_q   <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (launch) begin
        adr_q <= addr;
        dat_q <= wdata;
        we_q  <= we;
      end
      if (state_q == B_REQ && ack_i && !we_q)
        rdata_q <= dat_i;
    end
  end

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      B_IDLE: if (launch) state_d = B_REQ;
      B_REQ:  if (ack_i) state_d = B_DROP;
      B_DROP: begin
        if (!ack_i) begin
          done    = 1'b1;
          state_d = B_IDLE;
        end
      end
      default: state_d = B_IDLE;
    endcase
  end

  assign stb_o = (state_q == B_REQ);
  assign we_o  = stb_o & we_q;
  assign sel_o = stb_o ? 4'b0001 : 4'b0000;
  assign adr_o = adr_q;
  assign dat_o = dat_q;
  assign rdata = rdata_q;

endmodule

// File: rtl/text_console_writer.sv
// Byte-stream console: places characters on the 80x60
// text grid over the bus and scrolls by read/write copy.
module text_console_writer
  import video_pkg::*;
(
  input  logic              clk_25mhz,
  input  logic              rst_ni,
  input  logic [7:0]        char_i,
  input  logic              char_valid_i,
  output logic              char_ready_o,
  output logic              busy_o,
  output logic [6:0]        cur_col_o,
  output logic [5:0]        cur_row_o,
  output logic [ADDR_W-1:0] adr_o,
  output logic [31:0]       dat_o,
  output logic [3:0]        sel_o,
  output logic              we_o,
  output logic              stb_o,
  input  logic              ack_i,
  input  logic [31:0]       dat_i
);

  main_state_t       state_q, state_d;
  logic [6:0]        col_q, col_d;
  logic [5:0]        row_q, row_d;
  logic [7:0]        ch_q, ch_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              ff_q, ff_d;

  logic              req, we, done, newline;
  logic [ADDR_W-1:0] addr, cur_addr;
  logic [7:0]        wbyte;
  logic [31:0]       rdata;
  logic [7:0]        tab_col;
  logic              unused_rd;

  assign cur_addr = row_base(row_q) + ADDR_W'(col_q);
  assign tab_col  = ({1'b0, col_q} | 8'd7) + 8'd1;
  assign unused_rd = ^rdata[31:8];

  always_ff @(posedge clk_25mhz or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      ch_q    <= '0;
      ptr_q   <= '0;
      ff_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
      ff_q    <= ff_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    ch_d    = ch_q;
    ptr_d   = ptr_q;
    ff_d    = ff_q;
    req     = 1'b0;
    we      = 1'b0;
    addr    = cur_addr;
    wbyte   = ch_q;
    newline = 1'b0;
    case (state_q)
      IDLE: begin
        if (char_valid_i) begin
          ch_d    = char_i;
          state_d = DECODE;
        end
      end
      DECODE: begin
        state_d = IDLE;
        unique case (1'b1)
          ch_q == CC_CR: col_d = '0;
          ch_q == CC_LF: newline = 1'b1;
          ch_q == CC_TAB: begin
            if (tab_col >= 8'(COLS)) newline = 1'b1;
            else col_d = tab_col[6:0];
          end
          ch_q == CC_BS: begin
            if (col_q != '0) col_d = col_q - 7'd1;
          end
          ch_q == CC_FF: begin
            ptr_d   = '0;
            ff_d    = 1'b1;
            state_d = FILL_WR;
          end
          default: begin
            req     = 1'b1;
            we      = 1'b1;
            state_d = PUT;
          end
        endcase
      end
      PUT: begin
        req = 1'b1;
        we  = 1'b1;
        if (done) state_d = ADVANCE;
      end
      ADVANCE: begin
        state_d = IDLE;
        if (col_q == 7'(COLS - 1)) newline = 1'b1;
        else col_d = col_q + 7'd1;
      end
      SCR_RD: begin
        req  = 1'b1;
        addr = ptr_q;
        if (done) state_d = SCR_WR;
      end
      SCR_WR: begin
        req   = 1'b1;
        we    = 1'b1;
        addr  = ptr_q - COLS_A;
        wbyte = rdata[7:0];
        if (done) begin
          if (ptr_q == LAST_ADDR) begin
            ptr_d   = LAST_ROW_ADDR;
            state_d = FILL_WR;
          end else begin
            ptr_d   = ptr_q + ADDR_W'(1);
            state_d = SCR_RD;
          end
        end
      end
      FILL_WR: begin
        req   = 1'b1;
        we    = 1'b1;
        addr  = ptr_q;
        wbyte = FILL;
        if (done) begin
          if (ptr_q == LAST_ADDR) begin
            state_d = IDLE;
            if (ff_q) begin
              col_d = '0;
              row_d = '0;
              ff_d  = 1'b0;
            end
          end else begin
            ptr_d = ptr_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // bottom row: move the screen up instead of the cursor
    if (newline) begin
      col_d = '0;
      if (row_q == 6'(ROWS - 1)) begin
        ptr_d   = COLS_A;
        state_d = SCR_RD;
      end else begin
        row_d = row_q + 6'd1;
      end
    end
  end

  wb_single_master #(
    .AW(ADDR_W)
  ) u_bus (
    .clk   (clk_25mhz),
    .rst_n (rst_ni),
    .req   (req),
    .we    (we),
    .addr  (addr),
    .wdata ({24'h0, wbyte}),
    .done  (done),
    .rdata (rdata),
    .adr_o (adr_o),
    .dat_o (dat_o),
    .sel_o (sel_o),
    .we_o  (we_o),
    .stb_o (stb_o),
    .ack_i (ack_i),
    .dat_i (dat_i)
  );

  assign char_ready_o = (state_q == IDLE);
  assign busy_o       = ~char_ready_o;
  assign cur_col_o    = col_q;
  assign cur_row_o    = row_q;

endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer with a
// memory-backed slave model and a transaction log.
module tb_text_console_writer;

  logic        clk_25mhz = 1'b0;
  logic        rst_ni = 1'b0;
  logic [7:0]  char_i = 8'h00;
  logic        char_valid_i = 1'b0;
  logic        char_ready_o, busy_o;
  logic [6:0]  cur_col_o;
  logic [5:0]  cur_row_o;
  logic [12:0] adr_o;
  logic [31:0] dat_o;
  logic [3:0]  sel_o;
  logic        we_o, stb_o;
  logic        ack_r = 1'b0;
  logic        ack_hold = 1'b0;
  logic        ack_i;
  logic [31:0] dat_i = 32'h0;

  assign ack_i = ack_r | ack_hold;

  int errors = 0;
  int checks = 0;
  int ack_len = 2;
  int ack_cnt = 0;
  int viol = 0;
  logic        stb_prev = 1'b0;
  logic [12:0] adr_prev = '0;

  logic [7:0] mem [0:4799];
  int         log_adr[$];
  logic [7:0] log_dat[$];
  logic       log_we[$];
  logic [3:0] log_sel[$];

  text_console_writer dut (
    .clk_25mhz    (clk_25mhz),
    .rst_ni       (rst_ni),
    .char_i       (char_i),
    .char_valid_i (char_valid_i),
    .char_ready_o (char_ready_o),
    .busy_o       (busy_o),
    .cur_col_o    (cur_col_o),
    .cur_row_o    (cur_row_o),
    .adr_o        (adr_o),
    .dat_o        (dat_o),
    .sel_o        (sel_o),
    .we_o         (we_o),
    .stb_o        (stb_o),
    .ack_i        (ack_i),
    .dat_i        (dat_i)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  // slave: ack one cycle after stb, for ack_len cycles
  always @(posedge clk_25mhz) begin
    if (ack_cnt != 0) begin
      ack_cnt <= ack_cnt - 1;
      if (ack_cnt == 1) ack_r <= 1'b0;
    end else if (stb_o && !ack_i) begin
      ack_r   <= 1'b1;
      ack_cnt <= ack_len;
      log_adr.push_back(int'(adr_o));
      log_dat.push_back(dat_o[7:0]);
      log_we.push_back(we_o);
      log_sel.push_back(sel_o);
      if (adr_o < 13'd4800) begin
        if (we_o) mem[adr_o] <= dat_o[7:0];
        else dat_i <= {24'h0, mem[adr_o]};
      end
    end
  end

  // bus protocol monitor
  always @(negedge clk_25mhz) begin
    if ((stb_o && !stb_prev && ack_i) ||
        (stb_o && stb_prev && adr_o != adr_prev) ||
        (stb_o && sel_o != 4'b0001) ||
        (stb_o && dat_o[31:8] != 24'h0))
      viol <= viol + 1;
    stb_prev <= stb_o;
    adr_prev <= adr_o;
  end

  task automatic clear_log();
    log_adr.delete();
    log_dat.delete();
    log_we.delete();
    log_sel.delete();
  endtask

  task automatic wait_ready(input int budget);
    int n;
    n = 0;
    @(negedge clk_25mhz);
    while (!char_ready_o && n < budget) begin
      @(negedge clk_25mhz);
      n++;
    end
    if (!char_ready_o) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: ready=%b want 1 after %0d cycles",
               char_ready_o, budget);
    end
  endtask

  task automatic send(input logic [7:0] b);
    wait_ready(200);
    char_i = b;
    char_valid_i = 1'b1;
    @(posedge clk_25mhz);
    #1 char_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_25mhz);
    rst_ni = 1'b0;
    @(negedge clk_25mhz);
    rst_ni = 1'b1;
  endtask

  task automatic chk_cursor(input string nm,
                            input int c, input int r);
    checks++;
    if (cur_col_o !== 7'(c) || cur_row_o !== 6'(r)) begin
      errors++;
      $display("FAIL %s: cursor=(%0d,%0d) want (%0d,%0d)",
               nm, cur_col_o, cur_row_o, c, r);
    end
  endtask

  task automatic test_reset();
    #5;
    checks++;
    if ({stb_o, we_o, sel_o, adr_o, dat_o} !== '0) begin
      errors++;
      $display("FAIL reset_bus: stb=%b we=%b sel=%h adr=%0d dat=%h want 0",
               stb_o, we_o, sel_o, adr_o, dat_o);
    end
    checks++;
    if (char_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: ready=%b busy=%b want 1/0",
               char_ready_o, busy_o);
    end
    chk_cursor("reset_cursor", 0, 0);
    @(negedge clk_25mhz);
    rst_ni = 1'b1;
  endtask

  task automatic test_single_write();
    ack_len = 2;
    clear_log();
    viol = 0;
    send(8'h41);
    @(negedge clk_25mhz);
    checks++;
    if (stb_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL put_n1: stb=%b busy=%b want 0/1", stb_o, busy_o);
    end
    @(negedge clk_25mhz);
    checks++;
    if (stb_o !== 1'b1 || we_o !== 1'b1 || adr_o !== 13'd0 ||
        dat_o !== 32'h41 || sel_o !== 4'b0001) begin
      errors++;
      $display("FAIL put_n2: stb=%b we=%b adr=%0d dat=%h sel=%b want 1 1 0 41 0001",
               stb_o, we_o, adr_o, dat_o, sel_o);
    end
    wait_ready(50);
    checks++;
    if (log_adr.size() != 1 || log_adr[0] != 0 ||
        log_dat[0] !== 8'h41 || log_we[0] !== 1'b1) begin
      errors++;
      $display("FAIL put_log: n=%0d want one write of 41 at 0",
               log_adr.size());
    end
    chk_cursor("put_cursor", 1, 0);
    send(8'h42);
    wait_ready(50);
    checks++;
    if (log_adr.size() != 2 || log_adr[1] != 1 ||
        log_dat[1] !== 8'h42) begin
      errors++;
      $display("FAIL b2b_log: n=%0d want second write of 42 at 1",
               log_adr.size());
    end
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL bus_proto: violations=%0d want 0", viol);
    end
  endtask

  task automatic test_wrap_bs();
    do_reset();
    repeat (10) send(8'h0A);
    repeat (9) send(8'h09);
    repeat (7) send(8'h78);
    wait_ready(50);
    chk_cursor("wrap_setup", 79, 10);
    clear_log();
    send(8'h42);
    wait_ready(50);
    checks++;
    if (log_adr.size() != 1 || log_adr[0] != 879 ||
        log_dat[0] !== 8'h42) begin
      errors++;
      $display("FAIL wrap_write: n=%0d adr=%0d want one write at 879",
               log_adr.size(),
               log_adr.size() > 0 ? log_adr[0] : -1);
    end
    chk_cursor("wrap_cursor", 0, 11);
    clear_log();
    send(8'h08);
    wait_ready(50);
    chk_cursor("bs_col0", 0, 11);
    checks++;
    if (log_adr.size() != 0) begin
      errors++;
      $display("FAIL bs_bus: txns=%0d want 0", log_adr.size());
    end
  endtask

  task automatic test_controls();
    do_reset();
    repeat (3) send(8'h0A);
    repeat (5) send(8'h79);
    wait_ready(50);
    chk_cursor("ctl_setup", 5, 3);
    clear_log();
    send(8'h09);
    @(negedge clk_25mhz);
    checks++;
    if (char_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL tab_n1: ready=%b want 0", char_ready_o);
    end
    @(negedge clk_25mhz);
    checks++;
    if (char_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL tab_n2: ready=%b want 1", char_ready_o);
    end
    chk_cursor("tab_cursor", 8, 3);
    send(8'h0D);
    wait_ready(50);
    chk_cursor("cr_cursor", 0, 3);
    send(8'h0A);
    wait_ready(50);
    chk_cursor("lf_cursor", 0, 4);
    checks++;
    if (log_adr.size() != 0) begin
      errors++;
      $display("FAIL ctl_bus: txns=%0d want 0", log_adr.size());
    end
  endtask

  task automatic test_scroll();
    int rd, wr, seq, bad0, bad57, bad58, bad59;
    int ea;
    logic ew;
    do_reset();
    ack_len = 1;
    for (int i = 0; i < 4800; i++) mem[i] = 8'h00;
    for (int i = 0; i < 80; i++) begin
      mem[80 + i]   = 8'h31;
      mem[4720 + i] = 8'h39;
    end
    repeat (59) send(8'h0A);
    wait_ready(50);
    chk_cursor("scroll_setup", 0, 59);
    clear_log();
    send(8'h0A);
    wait_ready(50000);
    rd = 0; wr = 0; seq = 0;
    for (int i = 0; i < log_adr.size(); i++) begin
      if (log_we[i]) wr++;
      else rd++;
      if (i < 9440) begin
        ea = (i % 2 == 0) ? 80 + i / 2 : i / 2;
        ew = (i % 2 == 1);
      end else begin
        ea = 4720 + (i - 9440);
        ew = 1'b1;
      end
      if (log_adr[i] != ea || log_we[i] !== ew) seq++;
      if (i >= 9440 && log_dat[i] !== 8'h20) seq++;
    end
    checks++;
    if (rd != 4720 || wr != 4800) begin
      errors++;
      $display("FAIL scroll_count: reads=%0d writes=%0d want 4720/4800",
               rd, wr);
    end
    checks++;
    if (seq != 0) begin
      errors++;
      $display("FAIL scroll_order: bad=%0d want 0", seq);
    end
    bad0 = 0; bad57 = 0; bad58 = 0; bad59 = 0;
    for (int i = 0; i < 80; i++) begin
      if (mem[i] !== 8'h31) bad0++;
      if (mem[4560 + i] !== 8'h00) bad57++;
      if (mem[4640 + i] !== 8'h39) bad58++;
      if (mem[4720 + i] !== 8'h20) bad59++;
    end
    checks++;
    if (bad0 + bad57 + bad58 + bad59 != 0) begin
      errors++;
      $display("FAIL scroll_mem: bad r0=%0d r57=%0d r58=%0d r59=%0d want 0",
               bad0, bad57, bad58, bad59);
    end
    chk_cursor("scroll_cursor", 0, 59);
  endtask

  task automatic test_ff();
    int seq;
    ack_len = 1;
    clear_log();
    send(8'h0C);
    wait_ready(30000);
    seq = 0;
    for (int i = 0; i < log_adr.size(); i++)
      if (log_adr[i] != i || log_we[i] !== 1'b1 ||
          log_dat[i] !== 8'h20) seq++;
    checks++;
    if (log_adr.size() != 4800 || seq != 0) begin
      errors++;
      $display("FAIL ff_fill: n=%0d bad=%0d want 4800/0",
               log_adr.size(), seq);
    end
    chk_cursor("ff_cursor", 0, 0);
    checks++;
    if (char_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL ff_ready: ready=%b want 1", char_ready_o);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    logic seen;
    ack_len = 1;
    repeat (59) send(8'h0A);
    send(8'h0A);
    repeat (200) @(negedge clk_25mhz);
    n = 0;
    while (!ack_i && n < 20) begin
      @(negedge clk_25mhz);
      n++;
    end
    ack_hold = 1'b1;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (stb_o !== 1'b0 || busy_o !== 1'b0 ||
        cur_row_o !== 6'd0) begin
      errors++;
      $display("FAIL rst_mid: stb=%b busy=%b row=%0d want 0 0 0",
               stb_o, busy_o, cur_row_o);
    end
    @(negedge clk_25mhz);
    rst_ni = 1'b1;
    clear_log();
    send(8'h5A);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk_25mhz);
      if (stb_o) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || log_adr.size() != 0) begin
      errors++;
      $display("FAIL linger_ack: stb_seen=%b txns=%0d want 0/0",
               seen, log_adr.size());
    end
    ack_hold = 1'b0;
    wait_ready(50);
    checks++;
    if (log_adr.size() != 1 || log_adr[0] != 0 ||
        log_dat[0] !== 8'h5A || log_we[0] !== 1'b1) begin
      errors++;
      $display("FAIL z_write: n=%0d want one write of 5a at 0",
               log_adr.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 4800; i++) mem[i] = 8'h00;
    test_reset();
    test_single_write();
    test_wrap_bs();
    test_controls();
    test_scroll();
    test_ff();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
